// File: rtl/uart8_rx_buffer_pkg.sv
// Shared constants for the UART receive buffer: data width and default sizing.
package uart8_rx_buffer_pkg;
    localparam int UART_DATA_W       = 8;
    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_ERR_CNT_W = 8;
endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata whenever not empty.
// A push into a full FIFO is accepted only if a pop frees a slot in the same cycle.
module uart_sync_fifo
    import uart8_rx_buffer_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              drop
);
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              popOk;
    logic              accept;

    assign empty  = (level_q == '0);
    assign full   = (level_q == FULL_LEVEL);
    assign popOk  = pop && !empty;
    assign accept = push && (!full || popOk);
    assign drop   = push && full && !popOk;
    assign level  = level_q;
    assign rdata  = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
            if (popOk)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({accept, popOk})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (accept && !clr) mem[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/uart8_rx_buffer.sv
// Captures bytes from the UART receiver on rising done edges into a show-ahead FIFO,
// and keeps a sticky overflow flag plus a saturating framing-error count.
module uart8_rx_buffer
    import uart8_rx_buffer_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   rx_done,
    input  logic                   rx_err,
    input  logic [UART_DATA_W-1:0] rx_data,
    output logic                   m_valid,
    output logic [UART_DATA_W-1:0] m_data,
    input  logic                   m_ready,
    output logic [ADDR_W:0]        level,
    output logic                   full,
    output logic                   overflow,
    output logic [ERR_CNT_W-1:0]   err_count
);
    logic                 done_q;
    logic                 err_q;
    logic                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 push;
    logic                 errEvt;
    logic                 pop;
    logic                 drop;
    logic                 empty;

    assign push      = rx_done && !done_q;
    assign errEvt    = rx_err && !err_q;
    assign m_valid   = !empty;
    assign pop       = m_valid && m_ready;
    assign overflow  = overflow_q;
    assign err_count = err_count_q;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(UART_DATA_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .push (push),
        .pop  (pop),
        .wdata(rx_data),
        .rdata(m_data),
        .level(level),
        .full (full),
        .empty(empty),
        .drop (drop)
    );

    always_comb begin
        overflow_d  = overflow_q;
        err_count_d = err_count_q;
        if (clr) begin
            overflow_d  = 1'b0;
            err_count_d = '0;
        end else begin
            if (drop) overflow_d = 1'b1;
            if (errEvt && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
        end
    end

    // Edge detectors keep tracking their inputs through clr so a held level is not re-captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            done_q      <= rx_done;
            err_q       <= rx_err;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: tb/tb_uart8_rx_buffer.sv
// Self-checking bench for uart8_rx_buffer: a queue-based model of the buffer is stepped
// every clock and compared with the DUT outputs on the falling edge.
module tb_uart8_rx_buffer;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       rx_done;
    logic       rx_err;
    logic [7:0] rx_data;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic [7:0] err_count;

    int testsRun = 0;
    int testsFailed = 0;

    byte unsigned modelQ[$];
    bit  modelPrevDone;
    bit  modelPrevErr;
    bit  modelOvf;
    int  modelErrCnt;

    uart8_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(4), .ERR_CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .rx_done  (rx_done),
        .rx_err   (rx_err),
        .rx_data  (rx_data),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .level    (level),
        .full     (full),
        .overflow (overflow),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Model of the buffer as a bounded byte queue with edge events, sticky overflow and a saturating count.
    task automatic modelReset();
        modelQ.delete();
        modelPrevDone = 1'b0;
        modelPrevErr  = 1'b0;
        modelOvf      = 1'b0;
        modelErrCnt   = 0;
    endtask

    task automatic modelStep();
        bit doneRise;
        bit errRise;
        if (!rst_n) begin
            modelReset();
            return;
        end
        doneRise      = rx_done && !modelPrevDone;
        errRise       = rx_err && !modelPrevErr;
        modelPrevDone = rx_done;
        modelPrevErr  = rx_err;
        if (clr) begin
            modelQ.delete();
            modelOvf    = 1'b0;
            modelErrCnt = 0;
            return;
        end
        if (m_ready && modelQ.size() > 0) void'(modelQ.pop_front());
        if (doneRise) begin
            if (modelQ.size() < DEPTH) modelQ.push_back(rx_data);
            else modelOvf = 1'b1;
        end
        if (errRise && modelErrCnt < 255) modelErrCnt++;
    endtask

    task automatic checkVal(string name, int actual, int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic checkOutput(string tag);
        int n;
        n = modelQ.size();
        checkVal({tag, ".m_valid"},   int'(m_valid),   (n != 0) ? 1 : 0);
        checkVal({tag, ".m_data"},    int'(m_data),    (n != 0) ? int'(modelQ[0]) : 0);
        checkVal({tag, ".level"},     int'(level),     n);
        checkVal({tag, ".full"},      int'(full),      (n == DEPTH) ? 1 : 0);
        checkVal({tag, ".overflow"},  int'(overflow),  int'(modelOvf));
        checkVal({tag, ".err_count"}, int'(err_count), modelErrCnt);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("cycle");
    endtask

    task automatic applyStimulus(bit done, bit err, byte unsigned data, bit ready, bit clear);
        rx_done = done;
        rx_err  = err;
        rx_data = data;
        m_ready = ready;
        clr     = clear;
        tick();
    endtask

    task automatic donePulse(byte unsigned data, int highCycles, int lowCycles);
        repeat (highCycles) applyStimulus(1'b1, 1'b0, data, 1'b0, 1'b0);
        repeat (lowCycles)  applyStimulus(1'b0, 1'b0, data, 1'b0, 1'b0);
    endtask

    task automatic clearPulse();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int lastByte;
        int firstByte;
        bit done;
        bit err;
        int readyPct;

        rst_n = 1'b0; clr = 1'b0; rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00; m_ready = 1'b0;
        modelReset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checkVal("reset.level", int'(level), 0);
        checkVal("reset.m_valid", int'(m_valid), 0);

        // Single byte held high for 16 cycles captures exactly once.
        applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        checkVal("single.m_valid", int'(m_valid), 1);
        checkVal("single.m_data", int'(m_data), 8'hA5);
        repeat (15) applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("single.level", int'(level), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("single.drained", int'(level), 0);

        // Fill to capacity then overflow with 0xFF.
        for (int i = 0; i < DEPTH; i++) donePulse(byte'(i), 2, 1);
        donePulse(8'hFF, 2, 1);
        checkVal("fill.full", int'(full), 1);
        checkVal("fill.level", int'(level), 16);
        checkVal("fill.overflow", int'(overflow), 1);
        for (int i = 0; i < DEPTH; i++) begin
            checkVal("fill.drainByte", int'(m_data), i);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkVal("fill.empty", int'(m_valid), 0);
        checkVal("fill.overflowSticky", int'(overflow), 1);
        clearPulse();

        // Push while full with a simultaneous pop.
        for (int i = 0; i < DEPTH; i++) donePulse(byte'(8'h10 + i), 1, 1);
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("fullPop.level", int'(level), 16);
        checkVal("fullPop.overflow", int'(overflow), 0);
        firstByte = int'(m_data);
        lastByte = -1;
        for (int i = 0; i < DEPTH; i++) begin
            lastByte = int'(m_data);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkVal("fullPop.firstByte", firstByte, 8'h11);
        checkVal("fullPop.lastByte", lastByte, 8'h77);

        // Framing errors, one coincident with a good byte, then saturation.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("err.count3", int'(err_count), 3);
        checkVal("err.level", int'(level), 1);
        checkVal("err.data", int'(m_data), 8'h3C);
        repeat (300) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        checkVal("err.saturated", int'(err_count), 255);

        // Clear while done is held high: no re-capture afterwards.
        clearPulse();
        for (int i = 0; i < DEPTH; i++) donePulse(byte'(i), 1, 1);
        donePulse(8'hEE, 1, 1);
        repeat (11) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkVal("clr.pre.level", int'(level), 5);
        checkVal("clr.pre.overflow", int'(overflow), 1);
        applyStimulus(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        checkVal("clr.level", int'(level), 0);
        checkVal("clr.overflow", int'(overflow), 0);
        checkVal("clr.err_count", int'(err_count), 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic with changing consumer pressure.
        done = 1'b0;
        err = 1'b0;
        for (int c = 0; c < 2400; c++) begin
            readyPct = (c < 800) ? 20 : ((c < 1600) ? 80 : 50);
            if ($urandom_range(0, 2) == 0) done = ~done;
            if ($urandom_range(0, 5) == 0) err = ~err;
            applyStimulus(done, err, byte'($urandom_range(0, 255)),
                          ($urandom_range(0, 99) < readyPct), ($urandom_range(0, 299) == 0));
        end

        // Async reset mid-stream, with done still high when reset releases.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        donePulse(8'h01, 1, 1);
        donePulse(8'h02, 1, 1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h03, 1'b0, 1'b0);
        checkVal("rst.pre.level", int'(level), 3);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkVal("rst.async.m_valid", int'(m_valid), 0);
        checkVal("rst.async.m_data", int'(m_data), 0);
        checkVal("rst.async.level", int'(level), 0);
        checkVal("rst.async.err_count", int'(err_count), 0);
        checkOutput("rst.async");
        tick();
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        checkVal("rst.firstEdge.level", int'(level), 1);
        checkVal("rst.firstEdge.data", int'(m_data), 8'h5A);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
